mem_req_tx: RTL and testbench

Request transmitter for the `mem_ctrl` source side. It accepts one 4-bit word per request plus a target select. It serializes the word into the three-beat valid sequence that the controller's SDRAM, flash and ROM receive channels expect. It sits between a stimulus/host port and `mem_ctrl`, and exposes toggle coverage in the same style as the controller.

---
 rtl/mem_req_tx_pkg.sv | 32 +++
 rtl/mem_req_tx_toggle_cov.sv | 28 ++
 rtl/mem_req_tx.sv | 175 +++++++++++++++++
 tb/tb_mem_req_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_tx_pkg.sv
// Shared encodings for the mem_ctrl request transmitter: channel targets,
// transmitter FSM states and the beat count of one transfer.
package mem_req_tx_pkg;

    typedef enum logic [1:0] {
        TGT_SDRAM   = 2'd0,
        TGT_FLASH   = 2'd1,
        TGT_ROM     = 2'd2,
        TGT_ILLEGAL = 2'd3
    } tgt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT1 = 3'd1,
        ST_BEAT2 = 3'd2,
        ST_BEAT3 = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [1:0] BEAT_COUNT = 2'd3;

    // Beat number 1..BEAT_COUNT while a beat is on the wire, 0 otherwise.
    function automatic logic [1:0] beat_num(input state_t s);
        case (s)
            ST_BEAT1: return 2'd1;
            ST_BEAT2: return 2'd2;
            ST_BEAT3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_tx_toggle_cov.sv
// Sticky toggle-coverage bit: set once the monitored signal has been seen
// both rising and falling since the last reset.
module toggle_cov (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic toggled
);

    logic prev;
    logic seen_rise;
    logic seen_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev      <= 1'b0;
            seen_rise <= 1'b0;
            seen_fall <= 1'b0;
        end else begin
            prev <= sig;
            if (sig && !prev) seen_rise <= 1'b1;
            if (!sig && prev) seen_fall <= 1'b1;
        end
    end

    assign toggled = seen_rise & seen_fall;

endmodule

// File: rtl/mem_req_tx.sv
// Request transmitter: accepts a 4-bit word plus target and serializes it into
// the three-beat valid sequence expected by the SDRAM, flash and ROM channels.
module mem_req_tx
    import mem_req_tx_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_target,
    input  logic [3:0] req_data,
    output logic       req_ready,
    input  logic       abort,
    input  logic       sdram_ready,
    input  logic       flash_ready,
    input  logic       rom_ready,
    output logic       sdram_valid,
    output logic [1:0] sdram_data_o,
    output logic       flash_valid,
    output logic [3:0] flash_data_o,
    output logic       rom_valid,
    output logic       rom_data_o,
    output logic       done,
    output logic       aborted,
    output logic       err,
    output logic [7:0] coverage
);

    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

    state_t     state, state_next;
    logic [1:0] gap_cnt, gap_cnt_next;
    tgt_t       lat_target, lat_target_next;
    logic [3:0] lat_data, lat_data_next;
    logic       aborted_q, aborted_next;
    logic       err_q, err_next;
    logic       sel_ready;
    logic       accept;
    logic [1:0] beat;
    logic       abort_ok;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready only ever rises in IDLE.
    always_comb begin
        case (tgt_t'(req_target))
            TGT_SDRAM: sel_ready = sdram_ready;
            TGT_FLASH: sel_ready = flash_ready;
            TGT_ROM:   sel_ready = rom_ready;
            default:   sel_ready = 1'b1;
        endcase
    end

    assign req_ready = !reset && (state == ST_IDLE) && sel_ready;
    assign accept    = req_valid && req_ready;

    assign beat     = beat_num(state);
    assign abort_ok = (beat != 2'd0) && (beat < BEAT_COUNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= 2'd0;
            lat_target <= TGT_SDRAM;
            lat_data   <= 4'd0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            gap_cnt    <= gap_cnt_next;
            lat_target <= lat_target_next;
            lat_data   <= lat_data_next;
            aborted_q  <= aborted_next;
            err_q      <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        gap_cnt_next    = gap_cnt;
        lat_target_next = lat_target;
        lat_data_next   = lat_data;
        aborted_next    = 1'b0;
        err_next        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (tgt_t'(req_target) == TGT_ILLEGAL) begin
                        err_next = 1'b1;
                    end else begin
                        state_next      = ST_BEAT1;
                        lat_target_next = tgt_t'(req_target);
                        lat_data_next   = req_data;
                    end
                end
            end
            ST_BEAT1, ST_BEAT2: begin
                if (abort && abort_ok) begin
                    state_next   = ST_IDLE;
                    aborted_next = 1'b1;
                end else begin
                    state_next = (state == ST_BEAT1) ? ST_BEAT2 : ST_BEAT3;
                end
            end
            // Beat 3 is the commit beat, so abort no longer applies here.
            ST_BEAT3: begin
                state_next   = ST_GAP;
                gap_cnt_next = 2'd0;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 2'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Channel outputs are pure decodes of state and the latched request.
    always_comb begin
        sdram_valid  = 1'b0;
        sdram_data_o = 2'b00;
        flash_valid  = 1'b0;
        flash_data_o = 4'd0;
        rom_valid    = 1'b0;
        rom_data_o   = 1'b0;
        if (beat != 2'd0) begin
            case (lat_target)
                TGT_SDRAM: begin
                    sdram_valid = 1'b1;
                    case (beat)
                        2'd1:    sdram_data_o = lat_data[1:0];
                        2'd2:    sdram_data_o = lat_data[3:2];
                        default: sdram_data_o = 2'b00;
                    endcase
                end
                TGT_FLASH: begin
                    flash_valid  = 1'b1;
                    flash_data_o = lat_data;
                end
                TGT_ROM: begin
                    rom_valid = 1'b1;
                    case (beat)
                        2'd1:    rom_data_o = lat_data[0];
                        2'd2:    rom_data_o = lat_data[1];
                        default: rom_data_o = lat_data[2];
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign done    = (state == ST_GAP) && (gap_cnt == 2'd0);
    assign aborted = aborted_q;
    assign err     = err_q;

    logic [7:0] cov_sig;
    assign cov_sig = {err, aborted, done,
                      state == ST_GAP, state == ST_BEAT3,
                      state == ST_BEAT2, state == ST_BEAT1,
                      state == ST_IDLE};

    for (genvar i = 0; i < 8; i++) begin : g_cov
        toggle_cov u_cov (
            .clock   (clock),
            .reset   (reset),
            .sig     (cov_sig[i]),
            .toggled (coverage[i])
        );
    end

endmodule

// File: tb/tb_mem_req_tx.sv
// Directed bench for mem_req_tx: a vector table for the per-target beat
// patterns plus hand-written sequences for abort, reset, ready and spacing.
module tb_mem_req_tx;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_target;
    logic [3:0] req_data;
    logic       req_ready;
    logic       abort;
    logic       sdram_ready, flash_ready, rom_ready;
    logic       sdram_valid;
    logic [1:0] sdram_data_o;
    logic       flash_valid;
    logic [3:0] flash_data_o;
    logic       rom_valid;
    logic       rom_data_o;
    logic       done, aborted, err;
    logic [7:0] coverage;

    int n_cmp = 0;
    int n_bad = 0;

    mem_req_tx #(.GAP_CYCLES(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_target   (req_target),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .abort        (abort),
        .sdram_ready  (sdram_ready),
        .flash_ready  (flash_ready),
        .rom_ready    (rom_ready),
        .sdram_valid  (sdram_valid),
        .sdram_data_o (sdram_data_o),
        .flash_valid  (flash_valid),
        .flash_data_o (flash_data_o),
        .rom_valid    (rom_valid),
        .rom_data_o   (rom_data_o),
        .done         (done),
        .aborted      (aborted),
        .err          (err),
        .coverage     (coverage)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Output vector layout: {sv, sd[1:0], fv, fd[3:0], rv, rd, done, aborted, err}
    localparam logic [12:0] EXP_NONE  = 13'd0;
    localparam logic [12:0] EXP_DONE  = 13'b0000000000100;
    localparam logic [12:0] EXP_ABORT = 13'b0000000000010;
    localparam logic [12:0] EXP_ERR   = 13'b0000000000001;

    function automatic logic [12:0] sd_b(input logic [1:0] d);
        return {1'b1, d, 10'b0};
    endfunction

    function automatic logic [12:0] fl_b(input logic [3:0] d);
        return {3'b0, 1'b1, d, 5'b0};
    endfunction

    function automatic logic [12:0] rom_b(input logic b);
        return {8'b0, 1'b1, b, 3'b0};
    endfunction

    function automatic logic [12:0] obs();
        return {sdram_valid, sdram_data_o, flash_valid, flash_data_o,
                rom_valid, rom_data_o, done, aborted, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input logic [12:0] exp);
        check(name, 32'(obs()), 32'(exp));
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        check(name, 32'(req_ready), 32'(exp));
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic start(input string name, input logic [1:0] tgt, input logic [3:0] data);
        req_valid  = 1'b1;
        req_target = tgt;
        req_data   = data;
        #1;
        chk_rdy({name, "_accept"}, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  tgt;
        logic [3:0]  data;
        logic [12:0] e1, e2, e3, e4;
    } vec_t;

    typedef struct {
        logic [1:0] tgt;
        logic [2:0] rdy;   // {sdram, flash, rom}
        logic       exp;
    } rdy_vec_t;

    vec_t     tab[8];
    rdy_vec_t rtab[7];

    initial begin
        int first_b1;
        int second_b1;

        tab[0] = '{2'd0, 4'hB, sd_b(2'b11), sd_b(2'b10), sd_b(2'b00), EXP_DONE};
        tab[1] = '{2'd2, 4'h5, rom_b(1'b1), rom_b(1'b0), rom_b(1'b1), EXP_DONE};
        tab[2] = '{2'd1, 4'h9, fl_b(4'h9), fl_b(4'h9), fl_b(4'h9), EXP_DONE};
        tab[3] = '{2'd0, 4'h6, sd_b(2'b10), sd_b(2'b01), sd_b(2'b00), EXP_DONE};
        tab[4] = '{2'd2, 4'h8, rom_b(1'b0), rom_b(1'b0), rom_b(1'b0), EXP_DONE};
        tab[5] = '{2'd1, 4'h0, fl_b(4'h0), fl_b(4'h0), fl_b(4'h0), EXP_DONE};
        tab[6] = '{2'd2, 4'h6, rom_b(1'b0), rom_b(1'b1), rom_b(1'b1), EXP_DONE};
        tab[7] = '{2'd3, 4'hF, EXP_ERR, EXP_NONE, EXP_NONE, EXP_NONE};

        rtab[0] = '{2'd0, 3'b011, 1'b0};
        rtab[1] = '{2'd0, 3'b100, 1'b1};
        rtab[2] = '{2'd1, 3'b101, 1'b0};
        rtab[3] = '{2'd1, 3'b010, 1'b1};
        rtab[4] = '{2'd2, 3'b110, 1'b0};
        rtab[5] = '{2'd2, 3'b001, 1'b1};
        rtab[6] = '{2'd3, 3'b000, 1'b1};

        // Clock/reset: hold an illegal request during reset, ready must stay low.
        reset = 1'b1; req_valid = 1'b1; req_target = 2'd3; req_data = 4'd0;
        abort = 1'b0; sdram_ready = 1'b1; flash_ready = 1'b1; rom_ready = 1'b1;
        repeat (3) cyc();
        chk_rdy("rst_ready_low", 1'b0);
        chk_obs("rst_outputs", EXP_NONE);
        check("rst_cov", 32'(coverage), 32'd0);
        reset = 1'b0; req_valid = 1'b0; req_target = 2'd0;
        cyc();
        chk_obs("post_rst_outputs", EXP_NONE);
        chk_rdy("post_rst_ready", 1'b1);

        // Reset asserted during BEAT2 clears everything on the next edge.
        cyc(); start("rst_b2", 2'd0, 4'hF);
        cyc(); req_valid = 1'b0; chk_obs("rst_b2_beat1", sd_b(2'b11));
        cyc(); chk_obs("rst_b2_beat2", sd_b(2'b11)); reset = 1'b1;
        cyc(); chk_obs("rst_b2_out0", EXP_NONE); chk_rdy("rst_b2_ready0", 1'b0);
        reset = 1'b0;
        cyc(); chk_obs("rst_b2_after", EXP_NONE);
        check("rst_b2_cov", 32'(coverage), 32'd0);

        // Ready decode in IDLE across targets and channel readiness.
        cyc();
        for (int i = 0; i < 7; i++) begin
            req_target = rtab[i].tgt;
            {sdram_ready, flash_ready, rom_ready} = rtab[i].rdy;
            #1;
            chk_rdy($sformatf("rdy_tab%0d", i), rtab[i].exp);
        end
        sdram_ready = 1'b1; flash_ready = 1'b1; rom_ready = 1'b1;

        // Vector table: accept, three beats, then done/err cycle, then idle.
        for (int i = 0; i < 8; i++) begin
            cyc(); start($sformatf("vec%0d", i), tab[i].tgt, tab[i].data);
            cyc(); req_valid = 1'b0; chk_obs($sformatf("vec%0d_c1", i), tab[i].e1);
            cyc(); chk_obs($sformatf("vec%0d_c2", i), tab[i].e2);
            cyc(); chk_obs($sformatf("vec%0d_c3", i), tab[i].e3);
            cyc(); chk_obs($sformatf("vec%0d_c4", i), tab[i].e4);
            chk_rdy($sformatf("vec%0d_rdy4", i), tab[i].tgt == 2'd3);
            cyc(); chk_obs($sformatf("vec%0d_c5", i), EXP_NONE);
            chk_rdy($sformatf("vec%0d_rdy5", i), 1'b1);
        end

        // Abort in BEAT1 (ROM).
        cyc(); start("ab1", 2'd2, 4'h7);
        cyc(); req_valid = 1'b0; chk_obs("ab1_beat1", rom_b(1'b1)); abort = 1'b1;
        cyc(); abort = 1'b0; chk_obs("ab1_aborted", EXP_ABORT);
        cyc(); chk_obs("ab1_quiet", EXP_NONE);

        // Abort in BEAT2 (flash): valid low and aborted at t+3, never done.
        cyc(); start("ab2", 2'd1, 4'hA);
        cyc(); req_valid = 1'b0; chk_obs("ab2_beat1", fl_b(4'hA));
        cyc(); chk_obs("ab2_beat2", fl_b(4'hA)); abort = 1'b1;
        cyc(); abort = 1'b0; chk_obs("ab2_aborted", EXP_ABORT);
        chk_rdy("ab2_idle_ready", 1'b1);
        cyc(); chk_obs("ab2_no_done", EXP_NONE);

        // Abort held from IDLE through GAP: only the BEAT1/BEAT2 samples count,
        // and this transfer keeps abort low there, so it must commit.
        cyc(); abort = 1'b1; start("ab3", 2'd0, 4'hB);
        cyc(); req_valid = 1'b0; abort = 1'b0; chk_obs("ab3_beat1", sd_b(2'b11));
        cyc(); chk_obs("ab3_beat2", sd_b(2'b10));
        cyc(); chk_obs("ab3_beat3", sd_b(2'b00)); abort = 1'b1;
        cyc(); chk_obs("ab3_done", EXP_DONE);
        cyc(); abort = 1'b0; chk_obs("ab3_gap_ignored", EXP_NONE);

        // Channel not ready blocks acceptance; raising it accepts that cycle.
        cyc(); sdram_ready = 1'b0; req_valid = 1'b1; req_target = 2'd0; req_data = 4'h3;
        #1; chk_rdy("nrdy_blocked", 1'b0);
        cyc(); chk_obs("nrdy_no_beat", EXP_NONE);
        sdram_ready = 1'b1; #1; chk_rdy("nrdy_raised", 1'b1);
        cyc(); req_valid = 1'b0; sdram_ready = 1'b0; chk_obs("nrdy_beat1", sd_b(2'b11));
        cyc(); chk_obs("nrdy_beat2", sd_b(2'b00));
        cyc(); chk_obs("nrdy_beat3", sd_b(2'b00));
        cyc(); chk_obs("nrdy_done", EXP_DONE); sdram_ready = 1'b1;

        // Back-to-back: second beat 1 lands exactly 4+GAP_CYCLES after the first.
        cyc(); start("b2b", 2'd0, 4'h1);
        first_b1 = -1;
        second_b1 = -1;
        for (int n = 1; n <= 15; n++) begin
            cyc();
            if (n == 1) req_data = 4'h2;
            if (sdram_valid && sdram_data_o == 2'b01 && first_b1 < 0) first_b1 = n;
            if (sdram_valid && sdram_data_o == 2'b10 && second_b1 < 0) begin
                second_b1 = n;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_first_beat", 32'(first_b1), 32'd1);
        check("b2b_spacing", 32'(second_b1 - first_b1), 32'd5);

        cyc();
        check("cov_full", 32'(coverage), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
